vga_fb_arbiter: RTL

- Shares one single-port framebuffer RAM between VGA scanout and the matrix-result writer.
- Scanout gets the port on every pixel-enable cycle inside the active window. The writer, and an internal clear engine, get every other cycle.
- Sits between the horizontal/vertical counters and the RGB444 pins.
- Each framebuffer word colours one 2^SCALE_SHIFT x 2^SCALE_SHIFT pixel block.

---
 rtl/vga_fb_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer sharing between VGA scanout,
// the matrix-result writer and a built-in clear engine. Scanout owns
// every active pixel-enable cycle; writer/clear use the remaining cycles.
module vga_fb_arbiter #(
    parameter int          H_START     = 144,
    parameter int          H_ACTIVE    = 640,
    parameter int          V_START     = 35,
    parameter int          V_ACTIVE    = 480,
    parameter int          SCALE_SHIFT = 3,
    parameter int          FB_W        = 80,
    parameter int          FB_H        = 60,
    parameter int          ADDR_W      = 13,
    parameter logic [11:0] CLEAR_VALUE = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [10:0]       h_count,
    input  logic [10:0]       v_count,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [11:0]       wr_data,
    output logic              wr_oob,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [11:0]       ram_wdata,
    input  logic [11:0]       ram_rdata,
    output logic              de,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b
);
    localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_W * FB_H - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [11:0]       wdata_q;
    logic              rd_pend, ce_d;
    logic              active, disp_slot;
    logic              wr_fire, wr_in_range, clr_last;
    logic [10:0]       h_rel, v_rel;
    logic [ADDR_W-1:0] disp_addr;

    assign active = (h_count >= 11'(H_START)) && (h_count < 11'(H_START + H_ACTIVE)) &&
                    (v_count >= 11'(V_START)) && (v_count < 11'(V_START + V_ACTIVE));
    assign disp_slot = clk_en && active;

    // Framebuffer word covering the current pixel block.
    assign h_rel = h_count - 11'(H_START);
    assign v_rel = v_count - 11'(V_START);
    assign disp_addr = ADDR_W'(v_rel >> SCALE_SHIFT) * ADDR_W'(FB_W) +
                       ADDR_W'(h_rel >> SCALE_SHIFT);

    assign wr_in_range = (wr_addr < FB_SIZE);
    assign clear_busy  = (state == CLEAR);

    // Port arbitration and FSM next state; addr/wdata hold when the port is idle.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_ready    = 1'b0;
        wr_fire     = 1'b0;
        clr_last    = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = addr_q;
        ram_wdata   = wdata_q;
        if (!reset) begin
            if (disp_slot) begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end
            case (state)
                IDLE: begin
                    // A clear request steals the cycle from the writer.
                    wr_ready = !disp_slot && !clear_req;
                    wr_fire  = wr_valid && wr_ready;
                    if (wr_fire && wr_in_range) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = wr_addr;
                        ram_wdata = wr_data;
                    end
                    if (clear_req) begin
                        state_nxt   = CLEAR;
                        clr_cnt_nxt = '0;
                    end
                end
                CLEAR: begin
                    if (!disp_slot) begin
                        ram_en      = 1'b1;
                        ram_we      = 1'b1;
                        ram_addr    = clr_cnt;
                        ram_wdata   = CLEAR_VALUE;
                        clr_cnt_nxt = clr_cnt + 1'b1;
                        if (clr_cnt == FB_LAST) begin
                            clr_last  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state, clear counter, held RAM address/data and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_oob     <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            addr_q     <= ram_addr;
            wdata_q    <= ram_wdata;
            wr_oob     <= wr_fire && !wr_in_range;
            clear_done <= clr_last;
        end
    end

    // Scanout pipeline: capture RAM data one cycle after the read, on the
    // delayed pixel enable, so colour changes only at pixel boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            ce_d    <= 1'b0;
            de      <= 1'b0;
            vga_r   <= 4'h0;
            vga_g   <= 4'h0;
            vga_b   <= 4'h0;
        end else begin
            rd_pend <= disp_slot;
            ce_d    <= clk_en;
            if (ce_d) begin
                de                    <= rd_pend;
                {vga_r, vga_g, vga_b} <= rd_pend ? ram_rdata : 12'h000;
            end
        end
    end
endmodule
